// File: rtl/bus_mem.sv
// MERA-400 system-bus memory responder: samples the bus, decodes block/page selection and
// answers read/write cycles from a local word array with rok_ (done) or ren_ (write refused).
module bus_mem #(
  parameter logic [3:0]  NB_ID                 = 4'd0,
  parameter logic [3:0]  BASE_PAGE             = 4'd0,
  parameter int unsigned PAGES_LOG2            = 1,
  parameter int unsigned WAIT_CYCLES           = 2,
  parameter bit          WRITE_DENY_FIRST_PAGE = 1'b0
) (
  input  logic        __clk,
  input  logic        clm_,
  input  logic        dmcl_,
  input  logic        dw_,
  input  logic        dr_,
  input  logic [0:3]  dnb_,
  input  logic [0:15] dad_,
  input  logic [0:15] ddt_,
  output logic        rok_,
  output logic        ren_,
  output logic [0:15] rdt_
);

  localparam int unsigned AW    = 12 + PAGES_LOG2;
  localparam int unsigned WORDS = 1 << AW;

  typedef enum logic [2:0] {StIdle, StSettle, StAccess, StAck, StNosel} state_e;

  logic        s_dw_, s_dr_, s_dmcl_;
  logic [0:3]  s_dnb_;
  logic [0:15] s_dad_, s_ddt_;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            op_wr_q;
  logic            deny_q;
  logic [AW-1:0]   addr_q;
  logic [15:0]     data_q;
  logic [15:0]     mem [WORDS];

  always_ff @(posedge __clk) begin
    if (!clm_) begin
      s_dw_   <= 1'b1;
      s_dr_   <= 1'b1;
      s_dmcl_ <= 1'b1;
      s_dnb_  <= 4'hf;
      s_dad_  <= 16'hffff;
      s_ddt_  <= 16'hffff;
    end else begin
      s_dw_   <= dw_;
      s_dr_   <= dr_;
      s_dmcl_ <= dmcl_;
      s_dnb_  <= dnb_;
      s_dad_  <= dad_;
      s_ddt_  <= ddt_;
    end
  end

  logic [15:0]   adr;
  logic [3:0]    nb;
  logic [4:0]    pdiff;
  logic [AW-1:0] loc_addr;
  logic          sel, one_strobe, both_strobes, no_strobe, mem_we;

  // pdiff[4] is the borrow; a borrowed difference is >= 16 and so never in range.
  always_comb begin
    adr          = ~s_dad_;
    nb           = ~s_dnb_;
    pdiff        = {1'b0, adr[15:12]} - {1'b0, BASE_PAGE};
    loc_addr     = AW'({pdiff[3:0], adr[11:0]});
    sel          = (nb == NB_ID) && (pdiff < 5'(32'd1 << PAGES_LOG2));
    one_strobe   = s_dw_ ^ s_dr_;
    both_strobes = !s_dw_ && !s_dr_;
    no_strobe    = s_dw_ && s_dr_;
    mem_we       = clm_ && s_dmcl_ && (state_q == StAccess) && (cnt_q == 4'd0) &&
                   op_wr_q && !deny_q;
  end

  always_ff @(posedge __clk) begin
    if (mem_we) mem[addr_q] <= data_q;
  end

  always_ff @(posedge __clk) begin
    if (!clm_ || !s_dmcl_) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rok_    <= 1'b1;
      ren_    <= 1'b1;
      rdt_    <= 16'hffff;
    end else begin
      case (state_q)
        StIdle: if (one_strobe) state_q <= StSettle;
        StSettle: begin
          if (no_strobe) begin
            state_q <= StIdle;
          end else if (both_strobes || !sel) begin
            state_q <= StNosel;
          end else begin
            state_q <= StAccess;
            op_wr_q <= !s_dw_;
            addr_q  <= loc_addr;
            data_q  <= ~s_ddt_;
            deny_q  <= WRITE_DENY_FIRST_PAGE && (pdiff == 5'd0);
            cnt_q   <= 4'(WAIT_CYCLES);
          end
        end
        StAccess: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= StAck;
            if (!op_wr_q) begin
              rdt_ <= ~mem[addr_q];
              rok_ <= 1'b0;
            end else if (deny_q) begin
              ren_ <= 1'b0;
            end else begin
              rok_ <= 1'b0;
            end
          end
        end
        StAck: begin
          if (no_strobe) begin
            state_q <= StIdle;
            rok_    <= 1'b1;
            ren_    <= 1'b1;
            rdt_    <= 16'hffff;
          end
        end
        StNosel: if (no_strobe) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_mem.sv
// Bench for bus_mem: four responders share one bus (wired-AND outputs); expected responses are
// queued as each cycle is driven and compared when the bus answers or the wait window expires.
module tb_bus_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clm_, dmcl_, dw_, dr_;
  logic [0:3]  dnb_;
  logic [0:15] dad_, ddt_;
  logic [3:0]  rok_v, ren_v;
  logic [0:15] rdt_v [4];
  logic        bus_rok, bus_ren;
  logic [0:15] bus_rdt;

  assign bus_rok = &rok_v;
  assign bus_ren = &ren_v;
  assign bus_rdt = rdt_v[0] & rdt_v[1] & rdt_v[2] & rdt_v[3];

  bus_mem #(.NB_ID(4'd0), .BASE_PAGE(4'd0), .PAGES_LOG2(1), .WAIT_CYCLES(2),
            .WRITE_DENY_FIRST_PAGE(1'b0)) u_mem0 (
    .__clk(clk), .clm_(clm_), .dmcl_(dmcl_), .dw_(dw_), .dr_(dr_), .dnb_(dnb_), .dad_(dad_),
    .ddt_(ddt_), .rok_(rok_v[0]), .ren_(ren_v[0]), .rdt_(rdt_v[0]));
  bus_mem #(.NB_ID(4'd1), .BASE_PAGE(4'd0), .PAGES_LOG2(1), .WAIT_CYCLES(0),
            .WRITE_DENY_FIRST_PAGE(1'b1)) u_mem1 (
    .__clk(clk), .clm_(clm_), .dmcl_(dmcl_), .dw_(dw_), .dr_(dr_), .dnb_(dnb_), .dad_(dad_),
    .ddt_(ddt_), .rok_(rok_v[1]), .ren_(ren_v[1]), .rdt_(rdt_v[1]));
  bus_mem #(.NB_ID(4'd2), .BASE_PAGE(4'd0), .PAGES_LOG2(1), .WAIT_CYCLES(15),
            .WRITE_DENY_FIRST_PAGE(1'b0)) u_mem2 (
    .__clk(clk), .clm_(clm_), .dmcl_(dmcl_), .dw_(dw_), .dr_(dr_), .dnb_(dnb_), .dad_(dad_),
    .ddt_(ddt_), .rok_(rok_v[2]), .ren_(ren_v[2]), .rdt_(rdt_v[2]));
  bus_mem #(.NB_ID(4'd4), .BASE_PAGE(4'd0), .PAGES_LOG2(1), .WAIT_CYCLES(4),
            .WRITE_DENY_FIRST_PAGE(1'b0)) u_mem4 (
    .__clk(clk), .clm_(clm_), .dmcl_(dmcl_), .dw_(dw_), .dr_(dr_), .dnb_(dnb_), .dad_(dad_),
    .ddt_(ddt_), .rok_(rok_v[3]), .ren_(ren_v[3]), .rdt_(rdt_v[3]));

  localparam int KNone  = 0;  // no responder may answer
  localparam int KWr    = 1;  // rok_, rdt_ idle
  localparam int KRd    = 2;  // rok_, rdt_ == data
  localparam int KDeny  = 3;  // ren_ only
  localparam int KRdNot = 4;  // rok_, rdt_ != data

  typedef struct {
    string       tag;
    int          kind;
    logic [15:0] rd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic bus_cycle(input string tag, input logic [3:0] nb, input logic [15:0] addr,
                           input bit wr, input bit rd, input logic [15:0] data, input int kind,
                           input logic [15:0] exp_rd, input int exp_lat);
    exp_t        e;
    int          n;
    bit          got;
    logic [15:0] rd_val;
    sb.push_back('{tag, kind, exp_rd, exp_lat});
    dnb_ = ~nb;
    dad_ = ~addr;
    ddt_ = ~data;
    dw_  = ~wr;
    dr_  = ~rd;
    @(posedge clk);  // edge k: first sample of the strobe
    n   = 0;
    got = 1'b0;
    while (!got && n < 24) begin
      @(posedge clk);
      #1;
      n++;
      if (!(bus_rok && bus_ren)) got = 1'b1;
    end
    e      = sb.pop_front();
    rd_val = ~bus_rdt;
    if (e.kind == KNone) begin
      check({e.tag, " quiet"}, 32'(got), 32'd0);
    end else begin
      check({e.tag, " lat"}, n, e.lat);
      check({e.tag, " rok"}, 32'(bus_rok), (e.kind == KDeny) ? 32'd1 : 32'd0);
      check({e.tag, " ren"}, 32'(bus_ren), (e.kind == KDeny) ? 32'd0 : 32'd1);
      check({e.tag, " excl"}, 32'(|(~rok_v & ~ren_v)), 32'd0);
      if (e.kind == KRd) check({e.tag, " data"}, rd_val, e.rd);
      else if (e.kind == KRdNot) check({e.tag, " data differs"}, 32'(rd_val != e.rd), 32'd1);
      else check({e.tag, " rdt idle"}, rd_val, 16'h0000);
    end
    dw_ = 1'b1;
    dr_ = 1'b1;
    if (got) begin
      @(posedge clk);  // edge m: first sample of released strobes
      #1;
      check({e.tag, " held"}, 32'(bus_rok & bus_ren), 32'd0);
      @(posedge clk);
      #1;
      check({e.tag, " release"}, {bus_rok, bus_ren, bus_rdt}, 18'h3ffff);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic watch_quiet(input string tag, input int edges);
    bit got;
    got = 1'b0;
    for (int i = 0; i < edges; i++) begin
      @(posedge clk);
      #1;
      if (!(bus_rok && bus_ren)) got = 1'b1;
    end
    check({tag, " quiet"}, 32'(got), 32'd0);
  endtask

  initial begin
    int n;
    clm_  = 1'b0;
    dmcl_ = 1'b1;
    dw_   = 1'b1;
    dr_   = 1'b1;
    dnb_  = 4'hf;
    dad_  = 16'hffff;
    ddt_  = 16'hffff;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {bus_rok, bus_ren, bus_rdt}, 18'h3ffff);
    clm_ = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    bus_cycle("a wr", 4'd0, 16'h0123, 1, 0, 16'hbeef, KWr, 16'h0, 5);
    bus_cycle("a rd", 4'd0, 16'h0123, 0, 1, 16'h0, KRd, 16'hbeef, 5);

    bus_cycle("b wr p1", 4'd1, 16'h1010, 1, 0, 16'h1234, KWr, 16'h0, 3);
    bus_cycle("b rd p1", 4'd1, 16'h1010, 0, 1, 16'h0, KRd, 16'h1234, 3);
    bus_cycle("c wr", 4'd2, 16'h0200, 1, 0, 16'hc0de, KWr, 16'h0, 18);
    bus_cycle("c rd", 4'd2, 16'h0200, 0, 1, 16'h0, KRd, 16'hc0de, 18);

    bus_cycle("a wr lo", 4'd0, 16'h0010, 1, 0, 16'h7777, KWr, 16'h0, 5);
    bus_cycle("a wr hi", 4'd0, 16'h1010, 1, 0, 16'h7777, KWr, 16'h0, 5);
    bus_cycle("nb3 wr", 4'd3, 16'h0010, 1, 0, 16'hdead, KNone, 16'h0, 0);
    bus_cycle("pg5 wr", 4'd0, 16'h5010, 1, 0, 16'hdead, KNone, 16'h0, 0);
    bus_cycle("a rd lo", 4'd0, 16'h0010, 0, 1, 16'h0, KRd, 16'h7777, 5);
    bus_cycle("a rd hi", 4'd0, 16'h1010, 0, 1, 16'h0, KRd, 16'h7777, 5);

    bus_cycle("b deny", 4'd1, 16'h0010, 1, 0, 16'h1111, KDeny, 16'h0, 3);
    bus_cycle("b rd deny", 4'd1, 16'h0010, 0, 1, 16'h0, KRdNot, 16'h1111, 3);

    // Master clear two edges into ACCESS of a 4-wait write: no rok_, location keeps 5555.
    bus_cycle("d wr", 4'd4, 16'h0040, 1, 0, 16'h5555, KWr, 16'h0, 7);
    dnb_ = ~4'd4;
    dad_ = ~16'h0040;
    ddt_ = ~16'haaaa;
    dw_  = 1'b0;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    dmcl_ = 1'b0;
    @(posedge clk);
    #1;
    dmcl_ = 1'b1;
    dw_   = 1'b1;
    watch_quiet("dmcl abort", 20);
    bus_cycle("d rd", 4'd4, 16'h0040, 0, 1, 16'h0, KRd, 16'h5555, 7);

    dnb_ = ~4'd0;
    dad_ = ~16'h0123;
    dr_  = 1'b0;
    @(posedge clk);
    #1;
    dr_ = 1'b1;
    watch_quiet("dr pulse", 12);
    bus_cycle("both", 4'd0, 16'h0123, 1, 1, 16'h0, KNone, 16'h0, 0);
    bus_cycle("a rd again", 4'd0, 16'h0123, 0, 1, 16'h0, KRd, 16'hbeef, 5);

    // Reset while the read is held in ACK.
    dnb_ = ~4'd0;
    dad_ = ~16'h0123;
    dr_  = 1'b0;
    @(posedge clk);
    n = 0;
    while (bus_rok && n < 24) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("clm ack lat", n, 5);
    clm_ = 1'b0;
    @(posedge clk);
    #1;
    check("clm release", {bus_rok, bus_ren, bus_rdt}, 18'h3ffff);
    clm_ = 1'b1;
    dr_  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus_cycle("a rd post clm", 4'd0, 16'h0123, 0, 1, 16'h0, KRd, 16'hbeef, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
